// File: rtl/alu_multicycle_pkg.sv
// Shared opcodes, FSM states and defaults for the multicycle EX-stage ALU.
package alu_multicycle_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SRA   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_XNOR  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_SLL   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_res,
  output logic [W-1:0] lo_res,
  output logic         dbz
);
  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  hi_q, lo_q, b_q;
  logic [CW-1:0] cnt;
  logic          div_q, dbz_q, neg_lo, neg_hi;
  logic          a_neg, b_neg;
  logic [W-1:0]  a_abs, b_abs;
  logic [W:0]    msum, dsh;
  logic [W+1:0]  ddf;
  logic [2*W-1:0] prod;

  assign a_neg = signed_op & a[W-1];
  assign b_neg = signed_op & b[W-1];
  assign a_abs = a_neg ? -a : a;
  assign b_abs = b_neg ? -b : b;

  assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign dsh  = {hi_q, lo_q[W-1]};
  assign ddf  = {1'b0, dsh} - {2'b00, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      div_q  <= 1'b0;
      dbz_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else if (start) begin
      div_q  <= is_div;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= is_div ? a_neg : (a_neg ^ b_neg);
      if (is_div && b == '0) begin
        // no iterations: result is fixed up on the very next edge
        dbz_q <= 1'b1;
        hi_q  <= a;
        lo_q  <= '1;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        dbz_q <= 1'b0;
        hi_q  <= '0;
        lo_q  <= is_div ? a_abs : b_abs;
        b_q   <= is_div ? b_abs : a_abs;
        busy  <= 1'b1;
        cnt   <= CW'(W);
      end
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1))
        busy <= 1'b0;
      if (div_q) begin
        if (!ddf[W+1]) begin
          hi_q <= ddf[W-1:0];
          lo_q <= {lo_q[W-2:0], 1'b1};
        end else begin
          hi_q <= dsh[W-1:0];
          lo_q <= {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_q <= msum[W:1];
        lo_q <= {msum[0], lo_q[W-1:1]};
      end
    end
  end

  assign done = busy && (cnt == CW'(1));
  assign dbz  = dbz_q;
  assign prod = neg_lo ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    hi_res = prod[2*W-1:W];
    lo_res = prod[W-1:0];
    if (dbz_q) begin
      hi_res = hi_q;
      lo_res = lo_q;
    end else if (div_q) begin
      hi_res = neg_hi ? -hi_q : hi_q;
      lo_res = neg_lo ? -lo_q : lo_q;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU: registered single-cycle ops plus iterative mul/div into HI/LO.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_reg_1,
  input  logic [WIDTH-1:0]   alu_reg_2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   alu_out,
  output logic               alu_zero,
  output logic               overflow,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  state_t state_q, state_d;

  logic             accept, is_mul, is_div, muldiv, start;
  logic             busy, done, dbz;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic [WIDTH-1:0] a, b, res, sum, dif;
  logic             ovf;

  assign a        = alu_reg_1;
  assign b        = alu_reg_2;
  assign in_ready = rst_n && (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
  assign is_div   = (alu_control == OP_DIV) || (alu_control == OP_DIVU);
  assign muldiv   = is_mul || is_div;
  assign start    = accept && muldiv && !flush;
  assign sum      = a + b;
  assign dif      = a - b;
  assign alu_zero = (alu_out == '0);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (alu_control)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOR:  res = ~(a | b);
      OP_ADD: begin
        res = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  res = b << shamt;
      OP_SRL:  res = b >> shamt;
      OP_SRA:  res = $signed(b) >>> shamt;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res = '0;
    endcase
  end

  alu_muldiv_iter #(.W(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op ((alu_control == OP_MULT) || (alu_control == OP_DIV)),
    .is_div    (is_div),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi_res    (hi_res),
    .lo_res    (lo_res),
    .dbz       (dbz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_div && b == '0) state_d = S_FIX;
          else if (is_div)       state_d = S_DIV;
          else                   state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)      state_d = S_IDLE;
        else if (done)  state_d = S_FIX;
        else if (!busy) state_d = S_IDLE;
      end
      S_FIX: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_out     <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !muldiv) begin
        out_valid   <= 1'b1;
        alu_out     <= res;
        overflow    <= ovf;
        div_by_zero <= 1'b0;
      end else if (state_q == S_FIX && !flush) begin
        out_valid   <= 1'b1;
        alu_out     <= lo_res;
        overflow    <= 1'b0;
        div_by_zero <= dbz;
        hi          <= hi_res;
        lo          <= lo_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'h0;
  logic [31:0] alu_reg_1 = '0;
  logic [31:0] alu_reg_2 = '0;
  logic [4:0]  shamt = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        overflow;
  logic        div_by_zero;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_multicycle dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .alu_reg_1   (alu_reg_1),
    .alu_reg_2   (alu_reg_2),
    .shamt       (shamt),
    .flush       (flush),
    .out_valid   (out_valid),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    alu_control = op;
    alu_reg_1   = a;
    alu_reg_2   = b;
    shamt       = sh;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    alu_reg_1 = 32'hDEAD_BEEF;
    alu_reg_2 = 32'h1234_5678;
    shamt     = 5'd13;
  endtask

  task automatic wait_result(output int lat, output int low);
    lat = 0;
    low = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready === 1'b0) low++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
    nvec++; if (alu_out !== 32'h0) begin nerr++; $display("FAIL rst alu_out: got %h want 0", alu_out); end
    nvec++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL rst hilo: got %h want 0", {hi, lo}); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rel in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    logic [3:0]  op [14];
    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [4:0]  vs [14];
    logic [31:0] ve [14];
    logic        vo [14];
    op = '{4'h2, 4'h6, 4'h7, 4'h8, 4'h4, 4'h0, 4'h1,
           4'h5, 4'hB, 4'hC, 4'hF, 4'h3, 4'h6, 4'h2};
    va = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
           32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
           32'hF0F0F0F0, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF};
    vb = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h80000000,
           32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
           32'hFF00FF00, 32'h1, 32'h80000000, 32'd1, 32'd1};
    vs = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0,
           5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd0, 5'd0};
    ve = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'hF8000000,
           32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F,
           32'h000F000F, 32'h80000000, 32'h08000000, 32'h7FFFFFFF, 32'h0};
    vo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      issue(op[i], va[i], vb[i], vs[i]);
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL sc%0d out_valid: got %b want 1", i, out_valid); end
      nvec++; if (alu_out !== ve[i]) begin nerr++; $display("FAIL sc%0d alu_out: got %h want %h", i, alu_out, ve[i]); end
      nvec++; if (overflow !== vo[i]) begin nerr++; $display("FAIL sc%0d overflow: got %b want %b", i, overflow, vo[i]); end
      nvec++; if (alu_zero !== (ve[i] == 0)) begin nerr++; $display("FAIL sc%0d alu_zero: got %b want %b", i, alu_zero, ve[i] == 0); end
      nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL sc%0d dbz: got %b want 0", i, div_by_zero); end
    end
    @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL sc pulse: got %b want 0", out_valid); end
    nvec++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL sc hilo: got %h want 0", {hi, lo}); end
  endtask

  task automatic test_mult;
    int lat, low;
    issue(4'h9, 32'hFFFFFFFD, 32'd7, 5'd0);
    wait_result(lat, low);
    nvec++; if (lat !== 33) begin nerr++; $display("FAIL mult lat: got %0d want 33", lat); end
    nvec++; if (low !== 33) begin nerr++; $display("FAIL mult busy: got %0d want 33", low); end
    nvec++; if (hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL mult hi: got %h want ffffffff", hi); end
    nvec++; if (lo !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mult lo: got %h want ffffffeb", lo); end
    nvec++; if (alu_out !== 32'hFFFFFFEB) begin nerr++; $display("FAIL mult out: got %h want ffffffeb", alu_out); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mult rdy: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back;
    alu_control = 4'h2;
    alu_reg_1   = 32'd40;
    alu_reg_2   = 32'd2;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL b2b valid: got %b want 1", out_valid); end
    nvec++; if (alu_out !== 32'd42) begin nerr++; $display("FAIL b2b out: got %h want 2a", alu_out); end
    nvec++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin nerr++; $display("FAIL b2b hilo: got %h want ffffffffffffffeb", {hi, lo}); end
  endtask

  task automatic test_div;
    int lat, low;
    issue(4'hD, 32'hFFFFFFF9, 32'd2, 5'd0);
    wait_result(lat, low);
    nvec++; if (lat !== 33) begin nerr++; $display("FAIL div lat: got %0d want 33", lat); end
    nvec++; if (lo !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div lo: got %h want fffffffd", lo); end
    nvec++; if (hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL div hi: got %h want ffffffff", hi); end
    issue(4'hE, 32'd7, 32'd0, 5'd0);
    wait_result(lat, low);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL dbz lat: got %0d want 1", lat); end
    nvec++; if (div_by_zero !== 1'b1) begin nerr++; $display("FAIL dbz flag: got %b want 1", div_by_zero); end
    nvec++; if (lo !== 32'hFFFFFFFF) begin nerr++; $display("FAIL dbz lo: got %h want ffffffff", lo); end
    nvec++; if (hi !== 32'd7) begin nerr++; $display("FAIL dbz hi: got %h want 7", hi); end
    issue(4'hD, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    wait_result(lat, low);
    nvec++; if ({hi, lo} !== 64'h00000000_80000000) begin nerr++; $display("FAIL min/-1 hilo: got %h want 80000000", {hi, lo}); end
    nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL min/-1 flag: got %b want 0", div_by_zero); end
    issue(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    wait_result(lat, low);
    nvec++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin nerr++; $display("FAIL multu hilo: got %h want fffffffe00000001", {hi, lo}); end
    issue(4'hE, 32'd100, 32'd7, 5'd0);
    wait_result(lat, low);
    nvec++; if ({hi, lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL divu hilo: got %h want 2/14", {hi, lo}); end
  endtask

  task automatic test_flush;
    int nov;
    issue(4'hA, 32'd5, 32'd6, 5'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush rdy: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush valid: got %b want 0", out_valid); end
    issue(4'h2, 32'd2, 32'd3, 5'd0);
    nvec++; if (out_valid !== 1'b1 || alu_out !== 32'd5) begin nerr++; $display("FAIL flush add: got %b/%h want 1/5", out_valid, alu_out); end
    nov = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) nov++;
    end
    nvec++; if (nov !== 0) begin nerr++; $display("FAIL flush ghost: got %0d want 0", nov); end
    nvec++; if ({hi, lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL flush hilo: got %h want 2/14", {hi, lo}); end
    @(negedge clk);
    flush       = 1'b1;
    alu_control = 4'h5;
    alu_reg_1   = 32'hFF;
    alu_reg_2   = 32'h0F;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    nvec++; if (out_valid !== 1'b1 || alu_out !== 32'hF0) begin nerr++; $display("FAIL idle flush: got %b/%h want 1/f0", out_valid, alu_out); end
  endtask

  task automatic test_reset_mid;
    int lat, low;
    issue(4'hD, 32'd100, 32'd3, 5'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (alu_out !== 32'h0 || out_valid !== 1'b0) begin nerr++; $display("FAIL mid rst out: got %b/%h want 0/0", out_valid, alu_out); end
    nvec++; if ({hi, lo} !== 64'h0) begin nerr++; $display("FAIL mid rst hilo: got %h want 0", {hi, lo}); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mid rst rdy: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mid rel rdy: got %b want 1", in_ready); end
    issue(4'hE, 32'd100, 32'd7, 5'd0);
    wait_result(lat, low);
    nvec++; if (lat !== 33) begin nerr++; $display("FAIL post rst lat: got %0d want 33", lat); end
    nvec++; if ({hi, lo} !== {32'd2, 32'd14}) begin nerr++; $display("FAIL post rst hilo: got %h want 2/14", {hi, lo}); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_mult;
    test_back_to_back;
    test_div;
    test_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
